// File: rtl/vga_fb_arbiter.sv
// ---------------------------------------------------------------------------
// vga_fb_arbiter
//
// Shares the single-port 24-bit VGA framebuffer between the scanout path and
// one pixel-writer client. Scanout reads always win during the active display
// region. Writer requests are queued in a small FIFO and drained into the RAM
// during blanking (any blanking, or vertical blanking only when vblank_only=1).
// Requests whose coordinates fall outside the visible area are discarded when
// they reach the FIFO head and are counted in drop_cnt.
//
// Ports
//   pclk, reset              pixel clock, synchronous active-high reset
//   scan_hvalid/scan_vvalid  timing generator active flags
//   scan_x, scan_y           current scan position (scan_y[9] unused)
//   vblank_only              restrict writes to vertical blanking
//   wr_valid/wr_ready        writer handshake; wr_x, wr_y, wr_data payload
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata   framebuffer RAM port
//   valid, vga_r/g/b         pixel output, one cycle behind the read
//   fifo_level               write FIFO occupancy
//   commit_cnt, drop_cnt     wrapping event counters
// ---------------------------------------------------------------------------
module vga_fb_arbiter #(
    parameter int FIFO_DEPTH = 4,
    parameter int H_PIX      = 640,
    parameter int V_PIX      = 480,
    localparam int AW        = $clog2(FIFO_DEPTH),
    localparam int LW        = AW + 1
) (
    input  logic          pclk,
    input  logic          reset,
    input  logic          scan_hvalid,
    input  logic          scan_vvalid,
    input  logic [9:0]    scan_x,
    input  logic [9:0]    scan_y,
    input  logic          vblank_only,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [9:0]    wr_x,
    input  logic [8:0]    wr_y,
    input  logic [23:0]   wr_data,
    output logic          mem_en,
    output logic          mem_we,
    output logic [18:0]   mem_addr,
    output logic [23:0]   mem_wdata,
    input  logic [23:0]   mem_rdata,
    output logic          valid,
    output logic [7:0]    vga_r,
    output logic [7:0]    vga_g,
    output logic [7:0]    vga_b,
    output logic [LW-1:0] fifo_level,
    output logic [15:0]   commit_cnt,
    output logic [15:0]   drop_cnt
);

    typedef struct packed {
        logic [9:0]  x;
        logic [8:0]  y;
        logic [23:0] rgb;
    } entry_t;

    // Port owner for the current cycle.
    typedef enum logic [1:0] {
        SEL_IDLE  = 2'd0,
        SEL_READ  = 2'd1,
        SEL_WRITE = 2'd2,
        SEL_DROP  = 2'd3
    } sel_e;

    localparam logic [10:0]   H_LIM    = 11'(H_PIX);
    localparam logic [9:0]    V_LIM    = 10'(V_PIX);
    localparam logic [LW-1:0] LVL_FULL = LW'(FIFO_DEPTH);

    entry_t          fifo_mem_q [FIFO_DEPTH];
    entry_t          fifo_mem_d [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]   level_q, level_d;
    logic [15:0]     commit_q, commit_d;
    logic [15:0]     drop_q, drop_d;
    logic            valid_q, valid_d;

    logic            active;
    logic            win;
    logic            fifo_empty;
    logic            head_in_range;
    logic            push;
    logic            pop;
    entry_t          head;
    sel_e            sel;
    logic            unused_scan_y;

    assign unused_scan_y = scan_y[9];

    // Window decode, FIFO head view and port-owner selection.
    always_comb begin
        active        = scan_hvalid & scan_vvalid;
        win           = vblank_only ? ~scan_vvalid : ~active;
        fifo_empty    = (level_q == '0);
        head          = fifo_mem_q[rd_ptr_q];
        head_in_range = ({1'b0, head.x} < H_LIM) && ({1'b0, head.y} < V_LIM);
        // The empty test uses the registered level, so an entry pushed this
        // cycle can only be popped from the next cycle on.
        if (reset) begin
            sel = SEL_IDLE;
        end else if (active) begin
            sel = SEL_READ;
        end else if (win && !fifo_empty) begin
            sel = head_in_range ? SEL_WRITE : SEL_DROP;
        end else begin
            sel = SEL_IDLE;
        end
    end

    // RAM port and handshake outputs driven from the selection.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = {head.x, head.y};
        mem_wdata = head.rgb;
        case (sel)
            SEL_READ: begin
                mem_en   = 1'b1;
                mem_addr = {scan_x, scan_y[8:0]};
            end
            SEL_WRITE: begin
                mem_en = 1'b1;
                mem_we = 1'b1;
            end
            default: begin
                mem_en = 1'b0;
            end
        endcase
        wr_ready = ~reset & (level_q != LVL_FULL);
        push     = wr_valid & wr_ready;
        pop      = (sel == SEL_WRITE) || (sel == SEL_DROP);
    end

    // Next-state for FIFO storage, pointers, level, counters and valid.
    always_comb begin
        fifo_mem_d = fifo_mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        commit_d   = commit_q;
        drop_d     = drop_q;
        valid_d    = active;
        if (push) begin
            fifo_mem_d[wr_ptr_q] = '{x: wr_x, y: wr_y, rgb: wr_data};
            wr_ptr_d             = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
        if (sel == SEL_WRITE) begin
            commit_d = commit_q + 16'd1;
        end else begin
            commit_d = commit_q;
        end
        if (sel == SEL_DROP) begin
            drop_d = drop_q + 16'd1;
        end else begin
            drop_d = drop_q;
        end
    end

    // Control state register; reset discards any queued entries.
    always_ff @(posedge pclk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            commit_q <= 16'd0;
            drop_q   <= 16'd0;
            valid_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            commit_q <= commit_d;
            drop_q   <= drop_d;
            valid_q  <= valid_d;
        end
    end

    // FIFO payload storage; contents are meaningless outside the level window.
    always_ff @(posedge pclk) begin
        fifo_mem_q <= fifo_mem_d;
    end

    // Pixel output: RAM data lines up with the registered active flag.
    always_comb begin
        valid      = valid_q;
        fifo_level = level_q;
        commit_cnt = commit_q;
        drop_cnt   = drop_q;
        if (valid_q) begin
            {vga_r, vga_g, vga_b} = mem_rdata;
        end else begin
            {vga_r, vga_g, vga_b} = 24'h0;
        end
    end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
module tb_vga_fb_arbiter;

    logic        pclk = 1'b0;
    logic        reset;
    logic        scan_hvalid, scan_vvalid;
    logic [9:0]  scan_x, scan_y;
    logic        vblank_only;
    logic        wr_valid;
    logic        wr_ready;
    logic [9:0]  wr_x;
    logic [8:0]  wr_y;
    logic [23:0] wr_data;
    logic        mem_en, mem_we;
    logic [18:0] mem_addr;
    logic [23:0] mem_wdata;
    logic [23:0] mem_rdata;
    logic        valid;
    logic [7:0]  vga_r, vga_g, vga_b;
    logic [2:0]  fifo_level;
    logic [15:0] commit_cnt, drop_cnt;

    int checks   = 0;
    int failures = 0;

    // Framebuffer RAM model plus write/collision monitors.
    logic [23:0] ram [0:524287];
    logic [23:0] rdata_q = 24'h0;
    int          wr_count = 0;
    int          bad_we   = 0;

    assign mem_rdata = rdata_q;

    always #5 pclk = ~pclk;

    vga_fb_arbiter dut (
        .pclk(pclk), .reset(reset),
        .scan_hvalid(scan_hvalid), .scan_vvalid(scan_vvalid),
        .scan_x(scan_x), .scan_y(scan_y), .vblank_only(vblank_only),
        .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .valid(valid), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .fifo_level(fifo_level), .commit_cnt(commit_cnt), .drop_cnt(drop_cnt)
    );

    // RAM behaviour: synchronous write, one-cycle read latency.
    always @(posedge pclk) begin
        if (mem_en && mem_we) begin
            ram[mem_addr] <= mem_wdata;
            wr_count      <= wr_count + 1;
        end
        if (mem_en && !mem_we) begin
            rdata_q <= ram[mem_addr];
        end
        if (mem_we && scan_hvalid && scan_vvalid) begin
            bad_we <= bad_we + 1;
        end
    end

    function automatic logic [31:0] adr(input int x, input int y);
        logic [18:0] a;
        a = {10'(x), 9'(y)};
        return {13'd0, a};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge pclk);
    endtask

    initial begin
        int saved;
        reset = 1'b1; scan_hvalid = 1'b1; scan_vvalid = 1'b1;
        scan_x = 10'd0; scan_y = 10'd0; vblank_only = 1'b0;
        wr_valid = 1'b1; wr_x = 10'd1; wr_y = 9'd1; wr_data = 24'hDEAD00;

        // Reset held: port forced idle, no acceptance.
        cyc(); #1;
        chk("rst_mem_en", 32'(mem_en), 32'd0);
        chk("rst_wr_ready", 32'(wr_ready), 32'd0);

        cyc(); reset = 1'b0; scan_hvalid = 1'b0; scan_vvalid = 1'b0; wr_valid = 1'b0; #1;
        chk("post_rst_wr_ready", 32'(wr_ready), 32'd1);
        chk("post_rst_level", 32'(fifo_level), 32'd0);
        chk("post_rst_commit", 32'(commit_cnt), 32'd0);
        chk("post_rst_drop", 32'(drop_cnt), 32'd0);
        chk("post_rst_valid", 32'(valid), 32'd0);
        chk("post_rst_rgb", {8'd0, vga_r, vga_g, vga_b}, 32'd0);
        chk("post_rst_mem_en", 32'(mem_en), 32'd0);
        chk("post_rst_mem_we", 32'(mem_we), 32'd0);

        // Preload {5,7}=123456 through the writer path during blanking.
        cyc(); wr_valid = 1'b1; wr_x = 10'd5; wr_y = 9'd7; wr_data = 24'h123456; #1;
        chk("pre_wr_ready", 32'(wr_ready), 32'd1);
        cyc(); wr_valid = 1'b0; #1;
        chk("pre_we", 32'(mem_we), 32'd1);
        chk("pre_addr", 32'(mem_addr), 32'h00A07);
        cyc(); #1;
        chk("pre_commit", 32'(commit_cnt), 32'd1);

        // Scanout read of {5,7}.
        cyc(); scan_hvalid = 1'b1; scan_vvalid = 1'b1; scan_x = 10'd5; scan_y = 10'd7; #1;
        chk("scan_en", 32'(mem_en), 32'd1);
        chk("scan_we", 32'(mem_we), 32'd0);
        chk("scan_addr", 32'(mem_addr), 32'h00A07);
        cyc(); scan_hvalid = 1'b0; scan_vvalid = 1'b0; #1;
        chk("scan_valid", 32'(valid), 32'd1);
        chk("scan_r", 32'(vga_r), 32'h12);
        chk("scan_g", 32'(vga_g), 32'h34);
        chk("scan_b", 32'(vga_b), 32'h56);
        cyc(); #1;
        chk("scan_valid_off", 32'(valid), 32'd0);
        chk("scan_rgb_off", {8'd0, vga_r, vga_g, vga_b}, 32'd0);

        // H-blank write with any-blanking window.
        cyc(); vblank_only = 1'b0; scan_hvalid = 1'b0; scan_vvalid = 1'b1;
        wr_valid = 1'b1; wr_x = 10'd3; wr_y = 9'd2; wr_data = 24'hFF0000; #1;
        chk("hb_same_cycle_en", 32'(mem_en), 32'd0);
        cyc(); wr_valid = 1'b0; #1;
        chk("hb_level1", 32'(fifo_level), 32'd1);
        chk("hb_we", 32'(mem_we), 32'd1);
        chk("hb_en", 32'(mem_en), 32'd1);
        chk("hb_addr", 32'(mem_addr), adr(3, 2));
        chk("hb_data", 32'(mem_wdata), 32'hFF0000);
        cyc(); #1;
        chk("hb_level0", 32'(fifo_level), 32'd0);
        chk("hb_commit", 32'(commit_cnt), 32'd2);

        // Deferral: vblank-only window, lines active, fill FIFO.
        vblank_only = 1'b1; scan_hvalid = 1'b1; scan_vvalid = 1'b1;
        scan_x = 10'd0; scan_y = 10'd0;
        for (int i = 0; i < 4; i++) begin
            cyc(); wr_valid = 1'b1; wr_x = 10'(10 + i); wr_y = 9'd1;
            wr_data = 24'(32'h111111 * (i + 1)); #1;
            chk("def_push_we", 32'(mem_we), 32'd0);
        end
        cyc(); wr_x = 10'd14; wr_data = 24'h555555; scan_hvalid = 1'b0; #1;
        chk("def_full_level", 32'(fifo_level), 32'd4);
        chk("def_full_ready", 32'(wr_ready), 32'd0);
        chk("def_hblank_we", 32'(mem_we), 32'd0);
        cyc(); scan_hvalid = 1'b1; #1;
        chk("def_stall_ready", 32'(wr_ready), 32'd0);
        chk("def_no_write_yet", 32'(wr_count), 32'd2);
        for (int i = 0; i < 5; i++) begin
            cyc();
            if (i == 0) begin
                scan_hvalid = 1'b0; scan_vvalid = 1'b0;
            end
            if (i == 2) wr_valid = 1'b0;
            #1;
            chk("def_drain_we", 32'(mem_we), 32'd1);
            chk("def_drain_addr", 32'(mem_addr), adr(10 + i, 1));
            chk("def_drain_data", 32'(mem_wdata), 32'h111111 * (i + 1));
            if (i < 2) chk("def_drain_ready", 32'(wr_ready), 32'(i));
        end
        cyc(); #1;
        chk("def_level0", 32'(fifo_level), 32'd0);
        chk("def_idle_en", 32'(mem_en), 32'd0);
        chk("def_commit", 32'(commit_cnt), 32'd7);

        // Collision: scanout keeps the port while writes wait.
        vblank_only = 1'b0; scan_hvalid = 1'b1; scan_vvalid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            cyc(); wr_valid = 1'b1; wr_x = 10'(20 + i); wr_y = 9'd3;
            wr_data = 24'(32'hABC000 + i); #1;
            chk("col_read_en", 32'(mem_en), 32'd1);
            chk("col_we", 32'(mem_we), 32'd0);
        end
        cyc(); wr_valid = 1'b0; #1;
        chk("col_level2", 32'(fifo_level), 32'd2);
        chk("col_hold_we", 32'(mem_we), 32'd0);
        cyc(); scan_hvalid = 1'b0; #1;
        chk("col_wr0_we", 32'(mem_we), 32'd1);
        chk("col_wr0_addr", 32'(mem_addr), adr(20, 3));
        chk("col_wr0_data", 32'(mem_wdata), 32'hABC000);
        cyc(); #1;
        chk("col_wr1_addr", 32'(mem_addr), adr(21, 3));
        chk("col_wr1_data", 32'(mem_wdata), 32'hABC001);
        cyc(); #1;
        chk("col_commit", 32'(commit_cnt), 32'd9);

        // Out-of-range writes during blanking are dropped.
        scan_hvalid = 1'b0; scan_vvalid = 1'b0;
        cyc(); wr_valid = 1'b1; wr_x = 10'd640; wr_y = 9'd0; wr_data = 24'h00FF00; #1;
        chk("oor_en0", 32'(mem_en), 32'd0);
        cyc(); wr_x = 10'd0; wr_y = 9'd480; #1;
        chk("oor_en1", 32'(mem_en), 32'd0);
        cyc(); wr_valid = 1'b0; #1;
        chk("oor_en2", 32'(mem_en), 32'd0);
        chk("oor_drop1", 32'(drop_cnt), 32'd1);
        cyc(); #1;
        chk("oor_drop", 32'(drop_cnt), 32'd2);
        chk("oor_commit", 32'(commit_cnt), 32'd9);
        chk("oor_level", 32'(fifo_level), 32'd0);

        // Reset with three queued entries.
        scan_hvalid = 1'b1; scan_vvalid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc(); wr_valid = 1'b1; wr_x = 10'(30 + i); wr_y = 9'd4; wr_data = 24'h0000AA; #1;
        end
        cyc(); wr_valid = 1'b0; #1;
        chk("rmo_level3", 32'(fifo_level), 32'd3);
        saved = wr_count;
        cyc(); reset = 1'b1; #1;
        chk("rmo_rst_en", 32'(mem_en), 32'd0);
        chk("rmo_rst_ready", 32'(wr_ready), 32'd0);
        cyc(); reset = 1'b0; scan_hvalid = 1'b0; scan_vvalid = 1'b0; #1;
        chk("rmo_level", 32'(fifo_level), 32'd0);
        chk("rmo_commit", 32'(commit_cnt), 32'd0);
        chk("rmo_drop", 32'(drop_cnt), 32'd0);
        chk("rmo_valid", 32'(valid), 32'd0);
        chk("rmo_en", 32'(mem_en), 32'd0);
        repeat (3) cyc();
        #1;
        chk("rmo_no_stale_write", 32'(wr_count), 32'(saved));
        chk("no_write_while_active", 32'(bad_we), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vga_fb_arbiter.md
# vga_fb_arbiter

Arbitrates the single-port 24-bit VGA framebuffer (640x480, address {x[9:0], y[8:0]}) between the scanout path and one pixel-writer client. Scanout reads have absolute priority during the active display region. Writes are buffered in a small FIFO and committed during blanking, either any blanking or vertical blanking only. The block sits between the VGA timing generator, the framebuffer RAM, and the RGB output pins.

## Interface
Parameters:
- `FIFO_DEPTH`, default 4: write-buffer entries; must be a power of two, at least 2.
- `H_PIX`, default 640: active width; writes with x >= H_PIX are dropped.
- `V_PIX`, default 480: active height; writes with y >= V_PIX are dropped.

Ports:
- `pclk` in 1: pixel clock; the only clock.
- `reset` in 1: synchronous, active-high.
- `scan_hvalid` in 1: timing generator horizontal active.
- `scan_vvalid` in 1: timing generator vertical active.
- `scan_x` in 10: current active pixel x; meaningful only when active.
- `scan_y` in 10: current active pixel y; only [8:0] used.
- `vblank_only` in 1: 0 = write in any blanking; 1 = write only while `scan_vvalid`=0.
- `wr_valid` in 1: writer request.
- `wr_ready` out 1: FIFO can accept.
- `wr_x` in 10: write x coordinate.
- `wr_y` in 9: write y coordinate.
- `wr_data` in 24: write RGB {r,g,b}.
- `mem_en` out 1: RAM enable.
- `mem_we` out 1: RAM write enable.
- `mem_addr` out 19: RAM address {x, y[8:0]}.
- `mem_wdata` out 24: RAM write data.
- `mem_rdata` in 24: RAM read data; valid 1 cycle after a read enable.
- `valid` out 1: pixel output valid.
- `vga_r` out 8: red.
- `vga_g` out 8: green.
- `vga_b` out 8: blue.
- `fifo_level` out 3: current FIFO occupancy, 0..FIFO_DEPTH; width is clog2(FIFO_DEPTH)+1.
- `commit_cnt` out 16: committed writes; wraps at 2^16.
- `drop_cnt` out 16: out-of-range writes discarded; wraps at 2^16.

## Operation
- `active = scan_hvalid & scan_vvalid`.
- `win = vblank_only ? ~scan_vvalid : ~active`.
- Memory port selection each cycle, combinational:
  - READ if `active`: `mem_en`=1, `mem_we`=0, `mem_addr`={scan_x, scan_y[8:0]}.
  - WRITE if `win` & FIFO non-empty & head in range: `mem_en`=1, `mem_we`=1, address and data from the FIFO head, then pop.
  - DROP if `win` & FIFO non-empty & head out of range: `mem_en`=0, pop, increment `drop_cnt`.
  - Otherwise idle: `mem_en`=0, `mem_we`=0. `mem_addr` and `mem_wdata` are don't-care but are held at the FIFO head value.
- READ and WRITE are mutually exclusive by construction, because `win` implies not `active`.
- One FIFO pop per cycle at most.
- FIFO:
  - Push when `wr_valid & wr_ready`. `wr_ready = (fifo_level != FIFO_DEPTH)`.
  - Push and pop in the same cycle leaves the level unchanged.
  - A push into an empty FIFO is not written to RAM in the same cycle; it is popped no earlier than the next cycle.
- Counters increment by 1 per event and wrap silently.
- Reset mid-operation: FIFO pointers and level go to 0 and pending entries are discarded. Counters clear. The pipeline register clears.

## Timing
- Read latency: a READ issued in cycle t presents its pixel in cycle t+1. `valid` is a registered copy of `active`. Outputs `{vga_r, vga_g, vga_b} = valid ? mem_rdata : 24'h0`.
- Write commit latency: accepted in cycle t, RAM write no earlier than t+1; with an empty FIFO and `win`=1 at t+1, exactly t+1.
- Throughput: one write per blanking cycle.
- Reset values:
  - `valid`=0, RGB=0.
  - `wr_ready`=1.
  - `fifo_level`=0.
  - `commit_cnt`=0, `drop_cnt`=0.
  - `mem_en`=0, `mem_we`=0.
- During reset, `mem_en` is forced to 0 and no push is accepted: `wr_ready` is forced to 0 while `reset`=1.
- Writer backpressure: `wr_data` and coordinates must be held stable while `wr_valid`=1 and `wr_ready`=0.

## Test plan
- Scanout only: preload RAM[{10'd5, 9'd7}]=24'h123456. Drive active with x=5, y=7 at cycle t. Required: `mem_en`=1, `mem_we`=0, `mem_addr`=19'h00A07 at t; `valid`=1 and r/g/b = 12/34/56 at t+1.
- Write in h-blank: `vblank_only`=0, `scan_hvalid`=0, `scan_vvalid`=1. Push (x=3, y=2, data FF0000). Required: RAM write addr {3,2}, data FF0000, in the next cycle; `commit_cnt`=1; `fifo_level` returns to 0.
- Deferral: `vblank_only`=1, lines active. Push 4 writes. Required: `fifo_level`=4 and `wr_ready`=0. A fifth `wr_valid` stalls. No RAM write occurs until `scan_vvalid`=0; the 4 writes then commit on 4 consecutive cycles in push order.
- Collision: active scanout with a non-empty FIFO and `vblank_only`=0. Required: every active cycle has `mem_we`=0; writes appear only in the first blanking cycles after `scan_hvalid` falls.
- Out of range: push x=640, y=0 and x=0, y=480 during blanking. Required: no `mem_en`; `drop_cnt`=2; `commit_cnt` unchanged.
- Reset mid-op: with 3 entries queued, assert `reset` for 1 cycle. Required: `fifo_level`=0, counters 0, `valid`=0, and no RAM write of the queued entries afterwards.
